// File: rtl/rll27_pkg.sv
// Shared constants for the RLL(2,7) code: codeword/data table and emit-state type.
// Codewords are right-aligned in the collector window; data is left-aligned on output.
package rll27_pkg;

    localparam int CW_MAX_LEN   = 8;
    localparam int DATA_MAX_LEN = 4;

    localparam logic [3:0] CW4_A  = 4'b0100;
    localparam logic [1:0] DAT4_A = 2'b10;
    localparam logic [3:0] CW4_B  = 4'b1000;
    localparam logic [1:0] DAT4_B = 2'b11;

    localparam logic [5:0] CW6_A  = 6'b000100;
    localparam logic [2:0] DAT6_A = 3'b000;
    localparam logic [5:0] CW6_B  = 6'b100100;
    localparam logic [2:0] DAT6_B = 3'b010;
    localparam logic [5:0] CW6_C  = 6'b001000;
    localparam logic [2:0] DAT6_C = 3'b011;

    localparam logic [7:0] CW8_A  = 8'b00100100;
    localparam logic [3:0] DAT8_A = 4'b0010;
    localparam logic [7:0] CW8_B  = 8'b00001000;
    localparam logic [3:0] DAT8_B = 4'b0011;

    typedef enum logic {
        IDLE,
        EMIT
    } emit_state_t;

endpackage

// File: rtl/rll27_cw_matcher.sv
// Combinational RLL(2,7) codeword lookup for a window of exactly len bits.
// Only lengths 4, 6 and 8 can hit; any other length is a miss.
module rll27_cw_matcher
    import rll27_pkg::*;
(
    input  logic [CW_MAX_LEN-1:0]   window,
    input  logic [3:0]              len,
    output logic                    hit,
    output logic [DATA_MAX_LEN-1:0] data,
    output logic [2:0]              data_len
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches.
        hit      = 1'b0;
        data     = '0;
        data_len = '0;
        case (len)
            4'd4: begin
                if (window[3:0] == CW4_A) begin
                    hit = 1'b1; data = {DAT4_A, 2'b00}; data_len = 3'd2;
                end else if (window[3:0] == CW4_B) begin
                    hit = 1'b1; data = {DAT4_B, 2'b00}; data_len = 3'd2;
                end
            end
            4'd6: begin
                if (window[5:0] == CW6_A) begin
                    hit = 1'b1; data = {DAT6_A, 1'b0}; data_len = 3'd3;
                end else if (window[5:0] == CW6_B) begin
                    hit = 1'b1; data = {DAT6_B, 1'b0}; data_len = 3'd3;
                end else if (window[5:0] == CW6_C) begin
                    hit = 1'b1; data = {DAT6_C, 1'b0}; data_len = 3'd3;
                end
            end
            4'd8: begin
                if (window == CW8_A) begin
                    hit = 1'b1; data = DAT8_A; data_len = 3'd4;
                end else if (window == CW8_B) begin
                    hit = 1'b1; data = DAT8_B; data_len = 3'd4;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rll27_decoder.sv
// Bit-serial RLL(2,7) decoder: collects code bits, matches codewords and
// re-emits the data bits serially; unmatched 8-bit windows are discarded and counted.
module rll27_decoder
    import rll27_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 code_i,
    input  logic                 code_valid_i,
    output logic                 data_o,
    output logic                 data_valid_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    logic [CW_MAX_LEN-1:0]   bits;
    logic [3:0]              cnt;
    logic [CW_MAX_LEN-1:0]   next_bits;
    logic [3:0]              next_cnt;
    logic                    hit;
    logic [DATA_MAX_LEN-1:0] match_data;
    logic [2:0]              match_len;
    logic                    load;
    logic                    window_full;
    logic                    err_detect;

    emit_state_t             state;
    logic [DATA_MAX_LEN-1:0] shifter;
    logic [2:0]              emit_cnt;

    // Matching looks at the collector as it will be after this edge.
    assign next_bits   = {bits[CW_MAX_LEN-2:0], code_i};
    assign next_cnt    = cnt + 4'd1;
    assign window_full = (next_cnt == 4'(CW_MAX_LEN));

    rll27_cw_matcher u_matcher (
        .window   (next_bits),
        .len      (next_cnt),
        .hit      (hit),
        .data     (match_data),
        .data_len (match_len)
    );

    assign load       = code_valid_i && hit;
    assign err_detect = code_valid_i && !hit && window_full;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bits <= '0;
            cnt  <= '0;
        end else if (code_valid_i) begin
            if (hit || window_full) begin
                bits <= '0;
                cnt  <= '0;
            end else begin
                bits <= next_bits;
                cnt  <= next_cnt;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            err_o <= err_detect;
            if (err_detect && (err_cnt_o != '1))
                err_cnt_o <= err_cnt_o + 1'b1;
        end
    end

    // A load takes priority over a shift so a word landing on the last emitted bit is not lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            shifter  <= '0;
            emit_cnt <= '0;
        end else if (load) begin
            state    <= EMIT;
            shifter  <= match_data;
            emit_cnt <= match_len;
        end else if (state == EMIT) begin
            shifter  <= {shifter[DATA_MAX_LEN-2:0], 1'b0};
            emit_cnt <= emit_cnt - 3'd1;
            if (emit_cnt == 3'd1)
                state <= IDLE;
        end
    end

    assign data_valid_o = (state == EMIT);
    assign data_o       = (state == EMIT) && shifter[DATA_MAX_LEN-1];

    load_never_truncates_emit: assert property (
        @(posedge clk_i) disable iff (rst_i)
        load |-> !((state == EMIT) && (emit_cnt > 3'd1))
    );

endmodule

// File: tb/tb_rll27_decoder.sv
// Scoreboard bench for rll27_decoder: expected data bits are queued as code is
// driven and popped by a monitor whenever data_valid_o is seen.
module tb_rll27_decoder;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       code_i = 1'b0;
    logic       code_valid_i = 1'b0;
    logic       data_o;
    logic       data_valid_o;
    logic       err_o;
    logic [7:0] err_cnt_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_q[$];

    rll27_decoder #(.ERR_CNT_W(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .code_i       (code_i),
        .code_valid_i (code_valid_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .err_o        (err_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: every valid data bit must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (!rst_i && data_valid_o) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: data_valid_o=1 data_o=%0b, required no output", data_o);
            end else begin
                logic e;
                e = exp_q.pop_front();
                if (data_o !== e) begin
                    n_fail++;
                    $display("FAIL data_bit: data_o=%0b, required %0b", data_o, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic send_bit(input logic b);
        @(negedge clk_i);
        code_i       = b;
        code_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        code_valid_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Drives a codeword MSB first, queuing its data before the final edge, and
    // checks the first data bit appears right after that edge.
    task automatic send_word(input logic [7:0] cw, input int len,
                             input logic [3:0] data, input int dlen, input int gap);
        for (int i = len - 1; i >= 0; i--) begin
            if (i == 0)
                for (int j = 0; j < dlen; j++) exp_q.push_back(data[3-j]);
            send_bit(cw[i]);
            if (i > 0 && gap > 0) idle_cycles(gap);
        end
        n_tests++;
        if (data_valid_o !== 1'b1 || data_o !== data[3]) begin
            n_fail++;
            $display("FAIL latency: valid=%0b data=%0b, required valid=1 data=%0b", data_valid_o, data_o, data[3]);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk_i);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d bits pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk_i);
        #1;
        n_tests++;
        if (data_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: data_valid_o=%0b, required 0", name, data_valid_o);
        end
    endtask

    task automatic test_reset;
        #3;
        n_tests++;
        if (data_o !== 1'b0 || data_valid_o !== 1'b0 || err_o !== 1'b0 || err_cnt_o !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: data=%0b valid=%0b err=%0b cnt=%0d, required all 0",
                     data_o, data_valid_o, err_o, err_cnt_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_single;
        send_word(8'b0000_0100, 4, 4'b1000, 2, 0);
        wait_drain("single");
        n_tests++;
        if (err_cnt_o !== 8'd0) begin
            n_fail++;
            $display("FAIL single_err: err_cnt_o=%0d, required 0", err_cnt_o);
        end
    endtask

    task automatic test_back_to_back;
        send_word(8'b0000_0100, 4, 4'b1000, 2, 0);
        send_word(8'b0000_1000, 4, 4'b1100, 2, 0);
        send_word(8'b0000_0100, 6, 4'b0000, 3, 0);
        wait_drain("back_to_back");
        n_tests++;
        if (err_cnt_o !== 8'd0) begin
            n_fail++;
            $display("FAIL back_to_back_err: err_cnt_o=%0d, required 0", err_cnt_o);
        end
    endtask

    task automatic test_six_bit_words;
        send_word(8'b0010_0100, 6, 4'b0100, 3, 0);
        send_word(8'b0000_1000, 6, 4'b0110, 3, 0);
        wait_drain("six_bit");
    endtask

    task automatic test_longest;
        send_word(8'b0010_0100, 8, 4'b0010, 4, 0);
        send_word(8'b0000_1000, 8, 4'b0011, 4, 0);
        wait_drain("longest");
    endtask

    task automatic test_valid_gaps;
        send_word(8'b0000_0100, 4, 4'b1000, 2, 3);
        wait_drain("valid_gaps");
    endtask

    task automatic test_error;
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        n_tests++;
        if (err_o !== 1'b1 || err_cnt_o !== 8'd1 || data_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL error_pulse: err=%0b cnt=%0d valid=%0b, required 1 1 0", err_o, err_cnt_o, data_valid_o);
        end
        idle_cycles(1);
        n_tests++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL error_width: err_o=%0b, required 0", err_o);
        end
        send_word(8'b0000_0100, 4, 4'b1000, 2, 0);
        wait_drain("error_resync");
        for (int w = 0; w < 300; w++) begin
            for (int i = 0; i < 8; i++) send_bit(1'b1);
            if (w == 253) begin
                n_tests++;
                if (err_cnt_o !== 8'd255) begin
                    n_fail++;
                    $display("FAIL error_reach_max: err_cnt_o=%0d, required 255", err_cnt_o);
                end
            end
        end
        n_tests++;
        if (err_cnt_o !== 8'd255) begin
            n_fail++;
            $display("FAIL error_saturate: err_cnt_o=%0d, required 255", err_cnt_o);
        end
    endtask

    task automatic test_reset_mid;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        #1 rst_i = 1'b1;
        #1;
        n_tests++;
        if (data_o !== 1'b0 || data_valid_o !== 1'b0 || err_o !== 1'b0 || err_cnt_o !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_collect: data=%0b valid=%0b err=%0b cnt=%0d, required all 0",
                     data_o, data_valid_o, err_o, err_cnt_o);
        end
        #1 rst_i = 1'b0;
        send_word(8'b0000_1000, 4, 4'b1100, 2, 0);
        wait_drain("reset_collect");

        send_word(8'b0000_1000, 4, 4'b1100, 2, 0);
        #1 rst_i = 1'b1;
        #1;
        n_tests++;
        if (data_o !== 1'b0 || data_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_emit: data=%0b valid=%0b, required 0 0", data_o, data_valid_o);
        end
        exp_q.delete();
        #1 rst_i = 1'b0;
        idle_cycles(2);
        n_tests++;
        if (data_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_emit_idle: data_valid_o=%0b, required 0", data_valid_o);
        end
        send_word(8'b0000_0100, 4, 4'b1000, 2, 0);
        wait_drain("reset_after");
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_six_bit_words;
        test_longest;
        test_valid_gaps;
        test_error;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rll27_decoder.md
Name: rll27_decoder

Overview:
- Downstream companion of the bit-serial RLL(2,7) encoder.
- Consumes the encoded channel bitstream one code bit per qualified clock, parses the variable-length RLL(2,7) codewords, and re-emits the original data bits serially.
- Flags undecodable sequences and keeps a saturating error count, so the lab link can be checked end-to-end (encoder → decoder).

Parameters:
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- code_i  input  1  encoded channel bit. Codeword MSB (leftmost) arrives first.
- code_valid_i  input  1  code_i is sampled only when high. Low = hold all collector state.
- data_o  output  1  decoded data bit, leftmost data bit first.
- data_valid_o  output  1  data_o is valid this cycle.
- err_o  output  1  one-cycle pulse: 8 code bits collected with no codeword match.
- err_cnt_o  output  ERR_CNT_W  number of err_o pulses since reset, saturating at all-ones.

Behaviour:
- Reset (async, any time, including mid-codeword or mid-emission): clears the collector (bits and count = 0), clears the output shifter and count. data_o=0, data_valid_o=0, err_o=0, err_cnt_o=0. After release, the first qualified code bit starts a fresh codeword.
- Code table, code → data (prefix-free):
  - 0100 → 10
  - 1000 → 11
  - 000100 → 000
  - 100100 → 010
  - 001000 → 011
  - 00100100 → 0010
  - 00001000 → 0011
- Collector:
  - 8-bit shift register plus 4-bit count (0..8).
  - On each edge with code_valid_i=1: next = {bits, code_i}, count+1.
  - Matching uses the next-state value, and only when the next count is 4, 6 or 8, against codewords of exactly that length.
- On match at edge k:
  - collector count → 0.
  - Output shifter loads the n data bits (n = len/2) and the emit count = n.
- On next count = 8 with no match, at edge k:
  - err_o=1 for the cycle after edge k.
  - err_cnt_o increments unless saturated.
  - collector cleared (resync by discard).
- Output FSM:
  - IDLE: data_valid_o=0, data_o=0.
  - EMIT: data_valid_o=1, data_o = shifter MSB. Each edge shifts left and decrements the count; leaves EMIT to IDLE when the count reaches 1.
- Latency:
  - The first data bit is valid in the cycle immediately after the edge that sampled the last code bit of a codeword.
  - The remaining bits follow on consecutive cycles with no gaps.
- Throughput guarantee:
  - The shortest codeword is 4 bits, so the next load occurs ≥4 edges after the previous one, and n ≤ 4.
  - Emission therefore always completes before the next load.
  - If a load nevertheless coincides with the EMIT last bit, the load wins and no bits are dropped. Assert in simulation that a load never occurs with emit count > 1.
- code_valid_i low: collector frozen; output emission continues independently.
- Simultaneous match and reset: reset wins.
- Not a frame aligner: the initial alignment is given by reset. Misalignment surfaces as err_o, followed by a retry from the next bit.

Decomposition:
- Package rll27_pkg:
  - CW_MAX_LEN=8, DATA_MAX_LEN=4.
  - Codeword and data constants for all 7 table entries.
  - typedef for the emit state (IDLE, EMIT).
- Sub-module rll27_cw_matcher: combinational.
  - Inputs: 8-bit window, length.
  - Outputs: hit, data bits [3:0] left-aligned, data length.
  - Shared with a future encoder-side self-checker.

Test Plan:
- Single codeword: reset, then code 0,1,0,0 on consecutive valid cycles → data_valid_o high for 2 cycles starting the cycle after the 4th bit, data_o = 1 then 0; err_o stays 0.
- Back-to-back stream: code 0100 1000 000100 (encoding of 10 11 000) → data bits 1,0,1,1,0,0,0; data_valid_o gaps only between groups; err_cnt_o=0.
- Longest words: 00100100 then 00001000 → data 0,0,1,0 then 0,0,1,1, each 4-cycle burst starting 1 cycle after the 8th code bit.
- Invalid/error: 8 bits of 1 → no data_valid_o; err_o pulses once after the 8th bit; err_cnt_o=1. Follow with 0100 → data 1,0. Drive 300 error windows → err_cnt_o saturates at 255.
- Valid gaps: 0100 with code_valid_i low for 3 cycles between every bit → same data 1,0, emitted the cycle after the last valid bit.
- Reset mid-operation: assert rst_i asynchronously after 3 bits of 000100 and again during an EMIT burst → outputs 0 immediately. Then feed 1000 → data 1,1, proving the collector was cleared.
